// File: rtl/timer_pkg.sv
// Shared register offsets, CTRL field layout and reset constants for the machine timer.
package timer_pkg;

  localparam logic [4:0] TIMER_MTIME_LO    = 5'h00;
  localparam logic [4:0] TIMER_MTIME_HI    = 5'h04;
  localparam logic [4:0] TIMER_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] TIMER_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] TIMER_CTRL        = 5'h10;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PRESCALE_LSB = 16;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Byte-lane merge: lanes with a low enable keep their old contents.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: emits a one-cycle tick every prescale+1 enabled cycles.
module timer_prescaler #(
  parameter int PrescaleW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [PrescaleW-1:0] prescale,
  input  logic                 clear,
  output logic                 tick
);

  logic [PrescaleW-1:0] pcnt;

  assign tick = en && (pcnt == prescale);

  // A disabled prescaler or a CTRL write restarts the count from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clear || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PrescaleW'(1);
    end
  end

endmodule

// File: rtl/timer_device.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaled tick and a level interrupt.
module timer_device
  import timer_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int PrescaleW    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [DataWidth/8-1:0]  device_be_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic                    device_rvalid_o,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    device_err_o,
  output logic                    timer_irq_o
);

  logic [63:0]          mtime, mtime_n;
  logic [63:0]          mtimecmp, mtimecmp_n;
  logic                 ctrl_en, ctrl_en_n;
  logic [PrescaleW-1:0] ctrl_prescale, ctrl_prescale_n;
  logic [31:0]          hi_shadow, hi_shadow_n;
  logic [31:0]          ctrl_view;
  logic [31:0]          rdata_n;
  logic [4:0]           offset;
  logic                 addr_err;
  logic                 wr_hit;
  logic                 rd_hit;
  logic                 ctrl_wr;
  logic                 tick;

  timer_prescaler #(.PrescaleW(PrescaleW)) u_prescaler (
    .clk      (clk_i),
    .rst      (rst_i),
    .en       (ctrl_en),
    .prescale (ctrl_prescale),
    .clear    (ctrl_wr),
    .tick     (tick)
  );

  assign offset   = device_addr_i[4:0];
  assign addr_err = (device_addr_i[1:0] != 2'b00) || (offset > TIMER_CTRL) ||
                    (device_addr_i[AddressWidth-1:5] != '0);
  assign wr_hit   = device_req_i && device_we_i && !addr_err;
  assign rd_hit   = device_req_i && !device_we_i && !addr_err;
  assign ctrl_wr  = wr_hit && (offset == TIMER_CTRL);

  always_comb begin
    ctrl_view = '0;
    ctrl_view[CTRL_EN_BIT] = ctrl_en;
    ctrl_view[CTRL_PRESCALE_LSB +: PrescaleW] = ctrl_prescale;
  end

  // Next-state: a software write to an mtime half overrides that cycle's tick, with no carry.
  always_comb begin
    mtime_n         = tick ? mtime + 64'd1 : mtime;
    mtimecmp_n      = mtimecmp;
    ctrl_en_n       = ctrl_en;
    ctrl_prescale_n = ctrl_prescale;
    hi_shadow_n     = hi_shadow;
    rdata_n         = '0;

    if (wr_hit) begin
      case (offset)
        TIMER_MTIME_LO:
          mtime_n = {mtime[63:32], merge_bytes(mtime[31:0], device_wdata_i, device_be_i)};
        TIMER_MTIME_HI:
          mtime_n = {merge_bytes(mtime[63:32], device_wdata_i, device_be_i), mtime[31:0]};
        TIMER_MTIMECMP_LO:
          mtimecmp_n[31:0] = merge_bytes(mtimecmp[31:0], device_wdata_i, device_be_i);
        TIMER_MTIMECMP_HI:
          mtimecmp_n[63:32] = merge_bytes(mtimecmp[63:32], device_wdata_i, device_be_i);
        TIMER_CTRL: begin
          if (device_be_i[CTRL_EN_BIT/8]) ctrl_en_n = device_wdata_i[CTRL_EN_BIT];
          for (int i = 0; i < PrescaleW; i++) begin
            if (device_be_i[(CTRL_PRESCALE_LSB + i) / 8])
              ctrl_prescale_n[i] = device_wdata_i[CTRL_PRESCALE_LSB + i];
          end
        end
        default: ;
      endcase
    end

    if (rd_hit) begin
      case (offset)
        TIMER_MTIME_LO: begin
          rdata_n     = mtime[31:0];
          hi_shadow_n = mtime[63:32];
        end
        TIMER_MTIME_HI:    rdata_n = hi_shadow;
        TIMER_MTIMECMP_LO: rdata_n = mtimecmp[31:0];
        TIMER_MTIMECMP_HI: rdata_n = mtimecmp[63:32];
        TIMER_CTRL:        rdata_n = ctrl_view;
        default:           rdata_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime           <= '0;
      mtimecmp        <= MTIMECMP_RESET;
      ctrl_en         <= 1'b0;
      ctrl_prescale   <= '0;
      hi_shadow       <= '0;
      device_rvalid_o <= 1'b0;
      device_rdata_o  <= '0;
      device_err_o    <= 1'b0;
      timer_irq_o     <= 1'b0;
    end else begin
      mtime           <= mtime_n;
      mtimecmp        <= mtimecmp_n;
      ctrl_en         <= ctrl_en_n;
      ctrl_prescale   <= ctrl_prescale_n;
      hi_shadow       <= hi_shadow_n;
      device_rvalid_o <= device_req_i;
      device_rdata_o  <= rdata_n;
      device_err_o    <= device_req_i && addr_err;
      timer_irq_o     <= (mtime_n >= mtimecmp_n);
    end
  end

endmodule
